// File: rtl/cacheline_adapter_if.sv
// Cache line port (ufp) and 64-bit burst memory port (dfp) bundle.
// The adapter takes the slave view; the cache/memory side takes master.
interface cacheline_adapter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
);
   logic [ADDR_W-1:0] ufp_addr;
   logic              ufp_read;
   logic              ufp_write;
   logic [LINE_W-1:0] ufp_wdata;
   logic [LINE_W-1:0] ufp_rdata;
   logic              ufp_resp;
   logic [ADDR_W-1:0] dfp_addr;
   logic              dfp_read;
   logic              dfp_write;
   logic [BEAT_W-1:0] dfp_wdata;
   logic              dfp_ready;
   logic [ADDR_W-1:0] dfp_raddr;
   logic [BEAT_W-1:0] dfp_rdata;
   logic              dfp_rvalid;

   modport slave (
      input  ufp_addr, ufp_read, ufp_write, ufp_wdata,
      input  dfp_ready, dfp_raddr, dfp_rdata, dfp_rvalid,
      output ufp_rdata, ufp_resp,
      output dfp_addr, dfp_read, dfp_write, dfp_wdata
   );

   modport master (
      output ufp_addr, ufp_read, ufp_write, ufp_wdata,
      output dfp_ready, dfp_raddr, dfp_rdata, dfp_rvalid,
      input  ufp_rdata, ufp_resp,
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata
   );
endinterface

// File: rtl/cacheline_adapter.sv
// Cache line <-> fixed-length memory burst adapter.
// Define CACHELINE_ADAPTER_RADDR_CHECK_EN to filter read beats by dfp_raddr.
module cacheline_adapter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input logic               clk,
   input logic               rst_n,
   cacheline_adapter_if.slave bus
);
   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFS_W = $clog2(LINE_W / 8);

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      RD_REQ,
      RD_DATA,
      RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_line;
   logic              r_is_rd;
   logic              w_last;
   logic              w_beat_ok;
   logic [ADDR_W-1:0] w_aligned;

   assign w_last    = (r_cnt == CNT_W'(BEATS - 1));
   assign w_aligned = {bus.ufp_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
   assign w_beat_ok = bus.dfp_rvalid && (bus.dfp_raddr == r_addr);
`else
   logic w_unused_raddr;
   assign w_unused_raddr = ^bus.dfp_raddr;
   assign w_beat_ok      = bus.dfp_rvalid;
`endif

   always_comb begin
      w_next        = r_state;
      bus.ufp_resp  = 1'b0;
      bus.ufp_rdata = '0;
      bus.dfp_addr  = '0;
      bus.dfp_read  = 1'b0;
      bus.dfp_write = 1'b0;
      bus.dfp_wdata = '0;
      unique case (r_state)
         IDLE: begin
            if (bus.ufp_write)
               w_next = WR_BURST;
            else if (bus.ufp_read)
               w_next = RD_REQ;
         end
         WR_BURST: begin
            bus.dfp_write = 1'b1;
            bus.dfp_addr  = r_addr;
            bus.dfp_wdata = r_line[r_cnt*BEAT_W +: BEAT_W];
            if (bus.dfp_ready && w_last)
               w_next = RESP;
         end
         RD_REQ: begin
            bus.dfp_read = 1'b1;
            bus.dfp_addr = r_addr;
            if (bus.dfp_ready)
               w_next = RD_DATA;
         end
         RD_DATA: begin
            if (w_beat_ok && w_last)
               w_next = RESP;
         end
         RESP: begin
            bus.ufp_resp = 1'b1;
            if (r_is_rd)
               bus.ufp_rdata = r_line;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_line  <= '0;
         r_is_rd <= 1'b0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            IDLE: begin
               // write has priority; a concurrent read is picked up after RESP
               if (bus.ufp_write) begin
                  r_addr  <= w_aligned;
                  r_line  <= bus.ufp_wdata;
                  r_cnt   <= '0;
                  r_is_rd <= 1'b0;
               end else if (bus.ufp_read) begin
                  r_addr  <= w_aligned;
                  r_cnt   <= '0;
                  r_is_rd <= 1'b1;
               end
            end
            WR_BURST: begin
               if (bus.dfp_ready)
                  r_cnt <= r_cnt + 1'b1;
            end
            RD_DATA: begin
               if (w_beat_ok) begin
                  r_line[r_cnt*BEAT_W +: BEAT_W] <= bus.dfp_rdata;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reset, write/read bursts,
// priority, back-to-back, and stray read beat handling.
module tb_cacheline_adapter;
   localparam int AW = 32;
   localparam int LW = 256;
   localparam int BW = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cacheline_adapter_if #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) bus ();

   cacheline_adapter #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int nresp = 0;
   int resp_cyc = 0;
   int nrd = 0;
   int nwr = 0;
   int ovl = 0;
   logic [LW-1:0] cap;

   task automatic chk(input string tag, input logic [LW-1:0] got,
                      input logic [LW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // advance one cycle, sample just after the edge, act as the cache on resp
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.dfp_read) nrd++;
      if (bus.dfp_write) nwr++;
      if (bus.dfp_read && bus.dfp_write) ovl++;
      if (bus.ufp_resp) begin
         nresp++;
         resp_cyc = cyc;
         cap = bus.ufp_rdata;
         if (bus.ufp_write) bus.ufp_write = 1'b0;
         else bus.ufp_read = 1'b0;
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] ea,
                           input logic [LW-1:0] line, input string tg);
      int b;
      int start;
      b = 0;
      nresp = 0;
      nrd = 0;
      bus.ufp_addr  = a;
      bus.ufp_wdata = line;
      bus.ufp_write = 1'b1;
      bus.dfp_ready = 1'b1;
      start = cyc;
      for (int k = 0; k < 12 && nresp == 0; k++) begin
         step();
         if (bus.dfp_write && b < 4) begin
            chk({tg, "_addr"}, LW'(bus.dfp_addr), LW'(ea));
            chk({tg, "_beat"}, LW'(bus.dfp_wdata), LW'(line[b*BW +: BW]));
            b++;
         end
      end
      chk({tg, "_nbeats"}, LW'(b), LW'(4));
      chk({tg, "_resp_n"}, LW'(nresp), LW'(1));
      chk({tg, "_lat"}, LW'(resp_cyc - start), LW'(5));
      chk({tg, "_rdata0"}, cap, '0);
      chk({tg, "_nrd"}, LW'(nrd), LW'(0));
      step();
      chk({tg, "_pulse"}, LW'(bus.ufp_resp), LW'(0));
      chk({tg, "_idle_wr"}, LW'(bus.dfp_write), LW'(0));
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] ea,
                          input logic [LW-1:0] line, input int rdly,
                          input int gap, input bit stray,
                          input logic [LW-1:0] exp_line, input string tg);
      logic [BW-1:0] d [5];
      logic [AW-1:0] ra [5];
      int n;
      n = 0;
      for (int b = 0; b < 4; b++) begin
         if (stray && b == 2) begin
            d[n]  = 64'hBAD0_BAD0_BAD0_BAD0;
            ra[n] = 32'hDEAD_BEE0;
            n++;
         end
         d[n]  = line[b*BW +: BW];
         ra[n] = ea;
         n++;
      end
      nresp = 0;
      nrd = 0;
      bus.ufp_addr  = a;
      bus.ufp_read  = 1'b1;
      bus.dfp_ready = 1'b0;
      step();
      chk({tg, "_addr"}, LW'(bus.dfp_addr), LW'(ea));
      chk({tg, "_rd"}, LW'(bus.dfp_read), LW'(1));
      repeat (rdly) step();
      bus.dfp_ready = 1'b1;
      step();
      bus.dfp_ready = 1'b0;
      chk({tg, "_nrd"}, LW'(nrd), LW'(rdly + 1));
      chk({tg, "_rd_off"}, LW'(bus.dfp_read), LW'(0));
      for (int b = 0; b < n; b++) begin
         bus.dfp_rvalid = 1'b1;
         bus.dfp_rdata  = d[b];
         bus.dfp_raddr  = ra[b];
         step();
         bus.dfp_rvalid = 1'b0;
         repeat (gap) step();
      end
      for (int k = 0; k < 8 && nresp == 0; k++) step();
      chk({tg, "_resp_n"}, LW'(nresp), LW'(1));
      chk({tg, "_line"}, cap, exp_line);
      repeat (2) step();
      chk({tg, "_once"}, LW'(nresp), LW'(1));
   endtask

   logic [LW-1:0] la, l1, l3, l4w, l4r, l5w, l5r, l6, e6;
   logic [BW-1:0] bad_beat;

   initial begin
      la  = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
             64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
      l1  = {64'h1D1D_0000_0000_0003, 64'h1C1C_0000_0000_0002,
             64'h1B1B_0000_0000_0001, 64'h1A1A_0000_0000_0000};
      l3  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      l4w = {64'h4040_0000_0000_0003, 64'h4040_0000_0000_0002,
             64'h4040_0000_0000_0001, 64'h4040_0000_0000_0000};
      l4r = {64'h4141_FFFF_0000_0003, 64'h4141_FFFF_0000_0002,
             64'h4141_FFFF_0000_0001, 64'h4141_FFFF_0000_0000};
      l5w = {64'h5555_0000_DDDD_0003, 64'h5555_0000_DDDD_0002,
             64'h5555_0000_DDDD_0001, 64'h5555_0000_DDDD_0000};
      l5r = {64'h5A5A_1111_2222_0003, 64'h5A5A_1111_2222_0002,
             64'h5A5A_1111_2222_0001, 64'h5A5A_1111_2222_0000};
      l6  = {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
             64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
      bad_beat = 64'hBAD0_BAD0_BAD0_BAD0;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
      e6 = l6;
`else
      e6 = {l6[191:128], bad_beat, l6[127:0]};
`endif
      bus.ufp_addr   = '0;
      bus.ufp_read   = 1'b0;
      bus.ufp_write  = 1'b0;
      bus.ufp_wdata  = '0;
      bus.dfp_ready  = 1'b0;
      bus.dfp_raddr  = '0;
      bus.dfp_rdata  = '0;
      bus.dfp_rvalid = 1'b0;

      #1;
      chk("rst_resp", LW'(bus.ufp_resp), LW'(0));
      chk("rst_rdata", bus.ufp_rdata, '0);
      chk("rst_addr", LW'(bus.dfp_addr), LW'(0));
      chk("rst_read", LW'(bus.dfp_read), LW'(0));
      chk("rst_write", LW'(bus.dfp_write), LW'(0));
      chk("rst_wdata", LW'(bus.dfp_wdata), LW'(0));
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // reset after two write beats have retired
      nresp = 0;
      bus.ufp_addr  = 32'h0000_3000;
      bus.ufp_wdata = l1;
      bus.ufp_write = 1'b1;
      bus.dfp_ready = 1'b1;
      repeat (3) step();
      chk("t1_beat2", LW'(bus.dfp_wdata), LW'(64'h1C1C_0000_0000_0002));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_rst_write", LW'(bus.dfp_write), LW'(0));
      chk("t1_rst_addr", LW'(bus.dfp_addr), LW'(0));
      chk("t1_rst_wdata", LW'(bus.dfp_wdata), LW'(0));
      chk("t1_rst_resp", LW'(bus.ufp_resp), LW'(0));
      bus.ufp_write = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      chk("t1_noresp", LW'(nresp), LW'(0));

      do_write(32'h1234_5678, 32'h1234_5660, la, "t2");

      do_read(32'h0000_1044, 32'h0000_1040, l3, 3, 1, 1'b0, l3, "t3");

      bus.ufp_read = 1'b1;
      do_write(32'h2000_0010, 32'h2000_0000, l4w, "t4w");
      do_read(32'h2000_0010, 32'h2000_0000, l4r, 0, 0, 1'b0, l4r, "t4r");

      ovl = 0;
      do_write(32'h0000_2080, 32'h0000_2080, l5w, "t5w");
      do_read(32'h0000_4090, 32'h0000_4080, l5r, 1, 2, 1'b0, l5r, "t5r");
      chk("t5_overlap", LW'(ovl), LW'(0));

      do_read(32'h0000_6000, 32'h0000_6000, l6, 0, 1, 1'b1, e6, "t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
